// File: rtl/axi_lite_wr_slave.sv
// AXI4-Lite write slave: captures AW and W independently, merges WDATA into
// a word-addressed register file under WSTRB control and returns a B response.
//
// Ports:
//   ACLK, ARESET            clock (rising edge), async active-high reset
//   AWVALID/AWREADY/AWADDR  write address channel (byte address, [1:0] ignored)
//   WVALID/WREADY/WDATA/WSTRB  write data channel
//   BVALID/BREADY/BRESP     write response (00 OKAY, 10 SLVERR)
//   regs_out                register file, reg k at [32k+31:32k]
//   wr_pulse, wr_idx        one-cycle strobe and index of each committed update
module axi_lite_wr_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [ADDR_WIDTH-1:0]       AWADDR,
  input  logic                        WVALID,
  output logic                        WREADY,
  input  logic [31:0]                 WDATA,
  input  logic [3:0]                  WSTRB,
  output logic                        BVALID,
  input  logic                        BREADY,
  output logic [1:0]                  BRESP,
  output logic [32*NUM_REGS-1:0]      regs_out,
  output logic                        wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx
);

  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
  localparam int unsigned CMP_W  = WIDX_W + 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic              aw_held;
  logic              w_held;
  logic [WIDX_W-1:0] word_q;
  logic [31:0]       data_q;
  logic [3:0]        strb_q;
  logic [31:0]       regs [NUM_REGS];

  logic commit_c;
  logic in_range_c;
  logic unused_addr_lsb;

  // Byte offset bits never select anything; aligned word is always written.
  assign unused_addr_lsb = ^AWADDR[1:0];

  assign AWREADY = ~aw_held;
  assign WREADY  = ~w_held;

  // A commit waits for any outstanding response, so at most one is in flight.
  assign commit_c   = aw_held & w_held & ~BVALID;
  assign in_range_c = CMP_W'(word_q) < CMP_W'(NUM_REGS);

  // Channel capture, commit and response state.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      word_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      BVALID   <= 1'b0;
      BRESP    <= RESP_OKAY;
      wr_pulse <= 1'b0;
      wr_idx   <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_pulse <= 1'b0;

      // Capture cannot coincide with commit: capture needs held=0, commit held=1.
      if (AWVALID && AWREADY) begin
        aw_held <= 1'b1;
        word_q  <= AWADDR[ADDR_WIDTH-1:2];
      end
      if (WVALID && WREADY) begin
        w_held <= 1'b1;
        data_q <= WDATA;
        strb_q <= WSTRB;
      end

      if (BVALID && BREADY) BVALID <= 1'b0;

      if (commit_c) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        BVALID  <= 1'b1;
        if (in_range_c) begin
          for (int b = 0; b < 4; b++) begin
            if (strb_q[b]) regs[IDX_W'(word_q)][8*b +: 8] <= data_q[8*b +: 8];
          end
          BRESP    <= RESP_OKAY;
          wr_pulse <= 1'b1;
          wr_idx   <= IDX_W'(word_q);
        end else begin
          BRESP <= RESP_SLVERR;
        end
      end
    end
  end

  // Flatten register file onto the output bus.
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign regs_out[32*k +: 32] = regs[k];
  end

endmodule

// File: tb/tb_axi_lite_wr_slave.sv
// Self-checking bench for axi_lite_wr_slave: directed vector table, random
// transactions against a register-array model, and hand-written sequences
// for response backpressure and asynchronous reset mid-transaction.
module tb_axi_lite_wr_slave;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 8;

  logic                  ACLK = 1'b0;
  logic                  ARESET;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  WVALID;
  logic                  WREADY;
  logic [31:0]           WDATA;
  logic [3:0]            WSTRB;
  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;
  logic [32*NUM_REGS-1:0] regs_out;
  logic                  wr_pulse;
  logic [2:0]            wr_idx;

  axi_lite_wr_slave #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .regs_out(regs_out), .wr_pulse(wr_pulse), .wr_idx(wr_idx)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  exp_resp;
    logic        chk;
    logic [31:0] exp_reg;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [NUM_REGS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < NUM_REGS; k++)
      check($sformatf("reg%0d", k), 64'(regs_out[32*k +: 32]), 64'(model[k]));
  endtask

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Full transaction with BREADY high; entered with no response outstanding.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input int aw_dly, input int w_dly, input logic [1:0] exp_resp,
                        input logic chk, input logic [31:0] exp_reg);
    bit aw_done, w_done, aw_fire, w_fire;
    int c;
    logic [31:0] word;
    aw_done = 0; w_done = 0; c = 0;
    BREADY = 1'b1;
    word = addr >> 2;
    while (!(aw_done && w_done)) begin
      @(negedge ACLK);
      if (c > 30) begin
        checks++; errors++;
        $display("FAIL txn_timeout: handshake not seen for addr %0h, required within 30 cycles", addr);
        AWVALID = 1'b0; WVALID = 1'b0;
        return;
      end
      if (w_done && !aw_done) check("wready_while_held", 64'(WREADY), 64'(0));
      if (aw_done && !w_done) check("awready_while_held", 64'(AWREADY), 64'(0));
      AWVALID = !aw_done && (c >= aw_dly);
      AWADDR  = addr;
      WVALID  = !w_done && (c >= w_dly);
      WDATA   = data;
      WSTRB   = strb;
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      @(posedge ACLK);
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      c++;
    end
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    check("bvalid_before_commit", 64'(BVALID), 64'(0));
    if (word < NUM_REGS) model[word] = (model[word] & ~strb_mask(strb)) | (data & strb_mask(strb));
    @(negedge ACLK);
    check("bvalid", 64'(BVALID), 64'(1));
    check("bresp", 64'(BRESP), 64'(exp_resp));
    check("wr_pulse", 64'(wr_pulse), 64'(exp_resp == 2'b00));
    if (exp_resp == 2'b00) check("wr_idx", 64'(wr_idx), 64'(word));
    if (chk) check("target_reg", 64'(regs_out[32*word[2:0] +: 32]), 64'(exp_reg));
    check_regs();
    @(negedge ACLK);
    check("bvalid_cleared", 64'(BVALID), 64'(0));
    check("wr_pulse_cleared", 64'(wr_pulse), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [9];
    logic [31:0] addr;
    logic [31:0] word;
    logic [1:0]  saved_resp;

    tbl[0] = '{32'h04,       32'hDEADBEEF, 4'hF,    0, 0, 2'b00, 1'b1, 32'hDEADBEEF};
    tbl[1] = '{32'h08,       32'h11223344, 4'hF,    1, 0, 2'b00, 1'b1, 32'h11223344};
    tbl[2] = '{32'h08,       32'hAABBCCDD, 4'b0101, 0, 1, 2'b00, 1'b1, 32'h11BB33DD};
    tbl[3] = '{32'h0C,       32'h12345678, 4'hF,    3, 0, 2'b00, 1'b1, 32'h12345678};
    tbl[4] = '{32'h0E,       32'hCAFEF00D, 4'b0011, 0, 0, 2'b00, 1'b1, 32'h1234F00D};
    tbl[5] = '{32'h1C,       32'hFFFFFFFF, 4'h0,    0, 0, 2'b00, 1'b1, 32'h00000000};
    tbl[6] = '{32'h20,       32'h12345678, 4'hF,    0, 0, 2'b10, 1'b0, 32'h0};
    tbl[7] = '{32'h00,       32'h01020304, 4'b1000, 2, 2, 2'b00, 1'b1, 32'h01000000};
    tbl[8] = '{32'hFFFFFFFC, 32'hFFFFFFFF, 4'hF,    0, 0, 2'b10, 1'b0, 32'h0};

    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    ARESET = 1'b1; AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; WSTRB = '0; BREADY = 1'b1;

    // Reset values, during and after reset
    repeat (3) @(negedge ACLK);
    check("rst_awready", 64'(AWREADY), 64'(1));
    check("rst_wready", 64'(WREADY), 64'(1));
    check("rst_bvalid", 64'(BVALID), 64'(0));
    ARESET = 1'b0;
    @(negedge ACLK);
    check("rst_bresp", 64'(BRESP), 64'(0));
    check("rst_wr_pulse", 64'(wr_pulse), 64'(0));
    check("rst_wr_idx", 64'(wr_idx), 64'(0));
    check_regs();

    // Directed vector table
    for (int i = 0; i < 9; i++)
      do_txn(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].aw_dly, tbl[i].w_dly,
             tbl[i].exp_resp, tbl[i].chk, tbl[i].exp_reg);

    // Random transactions against the model
    for (int i = 0; i < 40; i++) begin
      addr = 32'($urandom_range(0, 47));
      word = addr >> 2;
      do_txn(addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), (word < NUM_REGS) ? 2'b00 : 2'b10, 1'b0, 32'h0);
    end

    // Backpressure: second pair captured while response stalls
    @(negedge ACLK);
    BREADY = 1'b0;
    AWVALID = 1'b1; AWADDR = 32'h10; WVALID = 1'b1; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    model[4] = 32'hA5A5A5A5;
    @(negedge ACLK);
    check("bp_bvalid1", 64'(BVALID), 64'(1));
    check("bp_pulse1", 64'(wr_pulse), 64'(1));
    check("bp_idx1", 64'(wr_idx), 64'(4));
    check("bp_reg4", 64'(regs_out[32*4 +: 32]), 64'(model[4]));
    saved_resp = BRESP;
    check("bp_bresp1", 64'(saved_resp), 64'(0));
    AWVALID = 1'b1; AWADDR = 32'h14; WVALID = 1'b1; WDATA = 32'h5A5A5A5A; WSTRB = 4'b0110;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    check("bp_awready_low", 64'(AWREADY), 64'(0));
    check("bp_wready_low", 64'(WREADY), 64'(0));
    check("bp_pulse_drop", 64'(wr_pulse), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("bp_bvalid_hold", 64'(BVALID), 64'(1));
      check("bp_bresp_hold", 64'(BRESP), 64'(0));
      check("bp_reg5_hold", 64'(regs_out[32*5 +: 32]), 64'(model[5]));
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    check("bp_bvalid_handshake", 64'(BVALID), 64'(0));
    check("bp_pulse_idle", 64'(wr_pulse), 64'(0));
    model[5] = (model[5] & ~strb_mask(4'b0110)) | (32'h5A5A5A5A & strb_mask(4'b0110));
    @(negedge ACLK);
    check("bp_bvalid2", 64'(BVALID), 64'(1));
    check("bp_pulse2", 64'(wr_pulse), 64'(1));
    check("bp_idx2", 64'(wr_idx), 64'(5));
    check_regs();
    @(negedge ACLK);
    check("bp_bvalid2_cleared", 64'(BVALID), 64'(0));

    // Asynchronous reset with a captured address and a pending response
    BREADY = 1'b0;
    AWVALID = 1'b1; AWADDR = 32'h18; WVALID = 1'b1; WDATA = 32'h0BADF00D; WSTRB = 4'hF;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    check("ar_bvalid", 64'(BVALID), 64'(1));
    AWVALID = 1'b1; AWADDR = 32'h1C;
    @(negedge ACLK);
    AWVALID = 1'b0;
    check("ar_aw_held", 64'(AWREADY), 64'(0));
    #2 ARESET = 1'b1;
    #1;
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    check("ar_bvalid_rst", 64'(BVALID), 64'(0));
    check("ar_bresp_rst", 64'(BRESP), 64'(0));
    check("ar_awready_rst", 64'(AWREADY), 64'(1));
    check("ar_wready_rst", 64'(WREADY), 64'(1));
    check("ar_pulse_rst", 64'(wr_pulse), 64'(0));
    check("ar_idx_rst", 64'(wr_idx), 64'(0));
    check_regs();
    @(negedge ACLK);
    ARESET = 1'b0;
    BREADY = 1'b1;
    do_txn(32'h1C, 32'h600DCAFE, 4'hF, 0, 2, 2'b00, 1'b1, 32'h600DCAFE);
    do_txn(32'h04, 32'h00C0FFEE, 4'b1100, 2, 0, 2'b00, 1'b1, 32'h00C00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
